// File: rtl/ex_iter_unit.sv
// Registered RV32 execute stage: single-cycle ALU plus iterative multiply and
// optional iterative shifts, with stall request/hold handshake toward MEM.
module ex_iter_unit #(
  parameter int XLEN       = 32,
  parameter int MUL_STEP   = 4,
  parameter int SHIFT_MODE = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid_i,
  input  logic [3:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic            wreg_i,
  input  logic [4:0]      waddr_i,
  input  logic [XLEN-1:0] storedata_i,
  input  logic            stall_i,
  output logic            out_valid_o,
  output logic [3:0]      op_o,
  output logic            wreg_o,
  output logic [4:0]      waddr_o,
  output logic [XLEN-1:0] rslt_o,
  output logic [XLEN-1:0] storedata_o,
  output logic            busy_o,
  output logic            rq_stall_o
);
  localparam int SW    = $clog2(XLEN);
  localparam int CW    = SW + 1;
  localparam int ITERS = XLEN / MUL_STEP;

  localparam logic [3:0] OP_ADD = 4'd1,  OP_SUB = 4'd2,  OP_AND = 4'd3,  OP_OR  = 4'd4;
  localparam logic [3:0] OP_XOR = 4'd5,  OP_SLT = 4'd6,  OP_SLTU = 4'd7, OP_SLL = 4'd8;
  localparam logic [3:0] OP_SRL = 4'd9,  OP_SRA = 4'd10, OP_MUL = 4'd11, OP_MULHU = 4'd12;
  localparam logic [3:0] OP_LDA = 4'd13, OP_STA = 4'd14;

  if ((XLEN < 8) || ((XLEN & (XLEN - 1)) != 0) || ((XLEN % MUL_STEP) != 0)) begin : g_bad_param
    $error("ex_iter_unit: illegal XLEN/MUL_STEP combination");
  end

  typedef enum logic [1:0] {IDLE, MUL, SHF, HOLD} state_t;

  typedef struct packed {
    logic            vld;
    logic [3:0]      op;
    logic            wreg;
    logic [4:0]      waddr;
    logic [XLEN-1:0] rslt;
    logic [XLEN-1:0] sd;
  } ex_out_t;

  function automatic logic [XLEN-1:0] alu(input logic [3:0] op, input logic [XLEN-1:0] a,
                                          input logic [XLEN-1:0] b);
    logic [SW-1:0] sh;
    sh  = b[SW-1:0];
    alu = '0;
    case (op)
      OP_ADD, OP_LDA, OP_STA: alu = a + b;
      OP_SUB:  alu = a - b;
      OP_AND:  alu = a & b;
      OP_OR:   alu = a | b;
      OP_XOR:  alu = a ^ b;
      OP_SLT:  alu = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
      OP_SLTU: alu = {{(XLEN-1){1'b0}}, a < b};
      OP_SLL:  alu = a << sh;
      OP_SRL:  alu = a >> sh;
      OP_SRA:  alu = $unsigned($signed(a) >>> sh);
      default: alu = '0;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] shf1(input logic [3:0] op, input logic [XLEN-1:0] v);
    case (op)
      OP_SLL:  shf1 = {v[XLEN-2:0], 1'b0};
      OP_SRL:  shf1 = {1'b0, v[XLEN-1:1]};
      default: shf1 = {v[XLEN-1], v[XLEN-1:1]};
    endcase
  endfunction

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [2*XLEN-1:0] acc, acc_nxt, opa, opa_nxt, mul_sum;
  logic [XLEN-1:0] opb, opb_nxt, shf_v, fin;
  ex_out_t         pend, pend_nxt, outr, out_nxt;
  logic            accept, is_mul, is_shf, done;

  assign accept  = (state == IDLE) && !stall_i && in_valid_i;
  assign is_mul  = (op_i == OP_MUL) || (op_i == OP_MULHU);
  assign is_shf  = (SHIFT_MODE != 0) && (op_i inside {OP_SLL, OP_SRL, OP_SRA}) &&
                   (b_i[SW-1:0] != '0);
  // opa is pre-shifted left each iteration, so the partial product lands in place
  assign mul_sum = acc + opa * {{(2*XLEN-MUL_STEP){1'b0}}, opb[MUL_STEP-1:0]};
  assign shf_v   = shf1(pend.op, opa[XLEN-1:0]);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    acc_nxt   = acc;
    opa_nxt   = opa;
    opb_nxt   = opb;
    pend_nxt  = pend;
    out_nxt   = stall_i ? outr : '0;
    fin       = '0;
    done      = 1'b0;
    unique case (state)
      IDLE: if (accept) begin
        pend_nxt = '{vld: 1'b1, op: op_i, wreg: wreg_i, waddr: waddr_i, rslt: '0, sd: storedata_i};
        if (is_mul) begin
          state_nxt = MUL;
          cnt_nxt   = '0;
          acc_nxt   = '0;
          opa_nxt   = {{XLEN{1'b0}}, a_i};
          opb_nxt   = b_i;
        end else if (is_shf) begin
          state_nxt = SHF;
          cnt_nxt   = {1'b0, b_i[SW-1:0]};
          opa_nxt   = {{XLEN{1'b0}}, a_i};
        end else begin
          out_nxt = '{vld: 1'b1, op: op_i, wreg: wreg_i, waddr: waddr_i,
                      rslt: alu(op_i, a_i, b_i), sd: storedata_i};
        end
      end
      MUL: begin
        acc_nxt = mul_sum;
        opa_nxt = opa << MUL_STEP;
        opb_nxt = opb >> MUL_STEP;
        cnt_nxt = cnt + CW'(1);
        if (cnt == CW'(ITERS - 1)) begin
          done = 1'b1;
          fin  = (pend.op == OP_MUL) ? mul_sum[XLEN-1:0] : mul_sum[2*XLEN-1:XLEN];
        end
      end
      SHF: begin
        opa_nxt = {{XLEN{1'b0}}, shf_v};
        cnt_nxt = cnt - CW'(1);
        if (cnt == CW'(1)) begin
          done = 1'b1;
          fin  = shf_v;
        end
      end
      HOLD: if (!stall_i) begin
        out_nxt   = pend;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (done) begin
      cnt_nxt = '0;
      if (stall_i) begin
        pend_nxt.rslt = fin;
        state_nxt     = HOLD;
      end else begin
        out_nxt      = pend;
        out_nxt.rslt = fin;
        state_nxt    = IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      acc   <= '0;
      opa   <= '0;
      opb   <= '0;
      pend  <= '0;
      outr  <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      acc   <= acc_nxt;
      opa   <= opa_nxt;
      opb   <= opb_nxt;
      pend  <= pend_nxt;
      outr  <= out_nxt;
    end
  end

  assign out_valid_o = outr.vld;
  assign op_o        = outr.op;
  assign wreg_o      = outr.wreg;
  assign waddr_o     = outr.waddr;
  assign rslt_o      = outr.rslt;
  assign storedata_o = outr.sd;
  assign busy_o      = (state != IDLE);
  assign rq_stall_o  = busy_o | stall_i;
endmodule

// File: tb/tb_ex_iter_unit.sv
// Bench for ex_iter_unit: iterative-shift DUT checked through a scoreboard,
// barrel-shift DUT checked directly against a vector table.
module tb_ex_iter_unit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid_i = 1'b0, stall_i = 1'b0, wreg_i = 1'b0;
  logic [3:0]  op_i = '0;
  logic [31:0] a_i = '0, b_i = '0, storedata_i = '0;
  logic [4:0]  waddr_i = '0;

  logic        ov_d, wreg_d, busy_d, rq_d, ov_b, wreg_b, busy_b, rq_b;
  logic [3:0]  op_d, op_b;
  logic [4:0]  waddr_d, waddr_b;
  logic [31:0] rslt_d, sd_d, rslt_b, sd_b;

  always #5 clk = ~clk;

  ex_iter_unit #(.XLEN(32), .MUL_STEP(4), .SHIFT_MODE(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid_i(in_valid_i), .op_i(op_i), .a_i(a_i), .b_i(b_i),
    .wreg_i(wreg_i), .waddr_i(waddr_i), .storedata_i(storedata_i), .stall_i(stall_i),
    .out_valid_o(ov_d), .op_o(op_d), .wreg_o(wreg_d), .waddr_o(waddr_d), .rslt_o(rslt_d),
    .storedata_o(sd_d), .busy_o(busy_d), .rq_stall_o(rq_d));

  ex_iter_unit #(.XLEN(32), .MUL_STEP(4), .SHIFT_MODE(0)) u_bar (
    .clk(clk), .rst_n(rst_n), .in_valid_i(in_valid_i), .op_i(op_i), .a_i(a_i), .b_i(b_i),
    .wreg_i(wreg_i), .waddr_i(waddr_i), .storedata_i(storedata_i), .stall_i(stall_i),
    .out_valid_o(ov_b), .op_o(op_b), .wreg_o(wreg_b), .waddr_o(waddr_b), .rslt_o(rslt_b),
    .storedata_o(sd_b), .busy_o(busy_b), .rq_stall_o(rq_b));

  typedef struct {
    logic [3:0]  op;
    logic        wreg;
    logic [4:0]  waddr;
    logic [31:0] rslt;
    logic [31:0] sd;
  } exp_t;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a, b;
    logic        wreg;
    logic [4:0]  waddr;
    logic [31:0] sd;
    logic [31:0] exp;
  } vec_t;

  exp_t sbq[$];
  int   checks = 0, failures = 0, outs = 0, pushed = 0;
  bit   loaded = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic push(input logic [3:0] op, input logic wreg, input logic [4:0] waddr,
                      input logic [31:0] rslt, input logic [31:0] sd);
    exp_t e;
    e.op = op; e.wreg = wreg; e.waddr = waddr; e.rslt = rslt; e.sd = sd;
    sbq.push_back(e);
    pushed++;
  endtask

  task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic wreg, input logic [4:0] waddr, input logic [31:0] sd);
    op_i = op; a_i = a; b_i = b; wreg_i = wreg; waddr_i = waddr; storedata_i = sd;
    in_valid_i = 1'b1;
    @(posedge clk); #1;
    in_valid_i = 1'b0;
  endtask

  task automatic wait_idle(input int max);
    int k;
    for (k = 0; k < max; k++) begin
      if (!busy_d && !busy_b) break;
      @(posedge clk); #1;
    end
    if (k == max) begin
      checks++; failures++;
      $display("FAIL wait_idle timeout actual=busy required=idle");
    end
  endtask

  // k: negedge index (1 = just after accept edge) where out_valid appears; st: rq_stall cycles before
  task automatic lat(output int k, output int st);
    k = 0; st = 0;
    for (int j = 1; j <= 60; j++) begin
      @(negedge clk);
      if (ov_d) begin k = j; break; end
      if (rq_d) st++;
    end
  endtask

  always @(posedge clk) loaded <= rst_n && !stall_i;

  always @(negedge clk) begin
    exp_t e;
    if (loaded && ov_d) begin
      outs++;
      if (sbq.size() == 0) begin
        checks++; failures++;
        $display("FAIL sb_unexpected actual=rslt %0h required=no output", rslt_d);
      end else begin
        e = sbq.pop_front();
        chk("sb_out", {op_d, wreg_d, waddr_d, rslt_d}, {e.op, e.wreg, e.waddr, e.rslt});
        chk("sb_sd", sd_d, e.sd);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[16];
    int   k, st, outs0;
    logic [31:0] ra, rb;
    logic [63:0] p;
    logic [3:0]  rop;

    vt[0]  = '{4'd1,  32'd5,          32'd7,          1'b1, 5'd3,  32'h0,        32'd12};
    vt[1]  = '{4'd2,  32'd0,          32'd1,          1'b1, 5'd4,  32'h0,        32'hFFFFFFFF};
    vt[2]  = '{4'd6,  32'hFFFFFFFF,   32'd1,          1'b1, 5'd5,  32'h0,        32'd1};
    vt[3]  = '{4'd7,  32'hFFFFFFFF,   32'd1,          1'b1, 5'd6,  32'h0,        32'd0};
    vt[4]  = '{4'd3,  32'hF0F0F0F0,   32'hFF00FF00,   1'b1, 5'd7,  32'h0,        32'hF000F000};
    vt[5]  = '{4'd4,  32'hF0F0F0F0,   32'hFF00FF00,   1'b1, 5'd8,  32'h0,        32'hFFF0FFF0};
    vt[6]  = '{4'd5,  32'hF0F0F0F0,   32'hFF00FF00,   1'b1, 5'd9,  32'h0,        32'h0FF00FF0};
    vt[7]  = '{4'd8,  32'd1,          32'd31,         1'b1, 5'd10, 32'h0,        32'h80000000};
    vt[8]  = '{4'd9,  32'h80000000,   32'd4,          1'b1, 5'd11, 32'h0,        32'h08000000};
    vt[9]  = '{4'd10, 32'h80000000,   32'd4,          1'b1, 5'd12, 32'h0,        32'hF8000000};
    vt[10] = '{4'd8,  32'h12345678,   32'h20,         1'b1, 5'd13, 32'h0,        32'h12345678};
    vt[11] = '{4'd13, 32'h1000,       32'hFFFFFFFC,   1'b1, 5'd14, 32'h0,        32'h00000FFC};
    vt[12] = '{4'd14, 32'h1000,       32'h10,         1'b0, 5'd0,  32'hDEADBEEF, 32'h00001010};
    vt[13] = '{4'd15, 32'd5,          32'd5,          1'b1, 5'd15, 32'h0,        32'd0};
    vt[14] = '{4'd1,  32'hFFFFFFFF,   32'd1,          1'b1, 5'd16, 32'h0,        32'd0};
    vt[15] = '{4'd10, 32'h80000001,   32'd1,          1'b1, 5'd17, 32'h0,        32'hC0000000};

    // reset state
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_out", {ov_d, busy_d, rslt_d, waddr_d, ov_b, busy_b}, 0);
    chk("rst_rq0", rq_d, 0);
    stall_i = 1'b1; #1;
    chk("rst_rq1", {rq_d, rq_b, busy_d}, 3'b110);
    stall_i = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 16; i++) begin
      push(vt[i].op, vt[i].wreg, vt[i].waddr, vt[i].exp, vt[i].sd);
      drive(vt[i].op, vt[i].a, vt[i].b, vt[i].wreg, vt[i].waddr, vt[i].sd);
      @(negedge clk);
      chk($sformatf("bar_v%0d", i), {ov_b, op_b, wreg_b, waddr_b, rslt_b},
          {1'b1, vt[i].op, vt[i].wreg, vt[i].waddr, vt[i].exp});
      chk($sformatf("bar_sd%0d", i), sd_b, vt[i].sd);
      wait_idle(40);
      @(negedge clk);
      chk($sformatf("bar_bubble%0d", i), {ov_b, op_b, wreg_b, waddr_b, rslt_b, sd_b}, 0);
    end

    // MUL / MULHU latency and result
    push(4'd11, 1'b1, 5'd20, 32'h00010000, 32'h0);
    drive(4'd11, 32'h00010000, 32'h00010001, 1'b1, 5'd20, 32'h0);
    lat(k, st);
    chk("mul_lat", k, 9);
    chk("mul_rq", st, 8);
    chk("bar_mul", {ov_b, rslt_b}, {1'b1, 32'h00010000});
    @(negedge clk);
    chk("mul_bubble", {ov_d, rq_d}, 0);
    push(4'd12, 1'b1, 5'd21, 32'h00000001, 32'h0);
    drive(4'd12, 32'h00010000, 32'h00010001, 1'b1, 5'd21, 32'h0);
    lat(k, st);
    chk("mulhu_lat", k, 9);
    chk("mulhu_rq", st, 8);
    wait_idle(20);

    // iterative shift latency, shamt=0 single-cycle
    push(4'd10, 1'b1, 5'd22, 32'hF8000000, 32'h0);
    drive(4'd10, 32'h80000000, 32'd4, 1'b1, 5'd22, 32'h0);
    lat(k, st);
    chk("sra_lat", k, 5);
    chk("sra_rq", st, 4);
    wait_idle(20);
    push(4'd8, 1'b1, 5'd23, 32'h000000A5, 32'h0);
    drive(4'd8, 32'h000000A5, 32'd0, 1'b1, 5'd23, 32'h0);
    lat(k, st);
    chk("sll0_lat", k, 1);
    wait_idle(20);

    // stall around MUL completion: HOLD, frozen outputs, single write-back
    push(4'd11, 1'b1, 5'd24, 32'h00012340, 32'h0);
    drive(4'd11, 32'h1234, 32'h10, 1'b1, 5'd24, 32'h0);
    repeat (6) @(posedge clk);
    #1;
    stall_i = 1'b1;
    outs0 = outs;
    @(posedge clk); #1;
    chk("hold_e8", {ov_d, rslt_d, busy_d}, {1'b0, 32'h0, 1'b1});
    @(posedge clk); #1;
    chk("hold_e9", {ov_d, rslt_d, busy_d, rq_d}, {1'b0, 32'h0, 1'b1, 1'b1});
    @(posedge clk); #1;
    chk("hold_e10", {ov_d, rslt_d, busy_d}, {1'b0, 32'h0, 1'b1});
    stall_i = 1'b0;
    @(posedge clk); #1;
    chk("hold_out", {ov_d, rslt_d, busy_d}, {1'b1, 32'h00012340, 1'b0});
    @(posedge clk); #1;
    chk("hold_once", {ov_d, outs - outs0}, {1'b0, 32'd1});

    // stall freezing a valid single-cycle result
    push(4'd1, 1'b1, 5'd9, 32'd5, 32'h0);
    drive(4'd1, 32'd2, 32'd3, 1'b1, 5'd9, 32'h0);
    stall_i = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
      chk("freeze", {ov_d, rslt_d, waddr_d, busy_d, rq_d}, {1'b1, 32'd5, 5'd9, 1'b0, 1'b1});
    end
    stall_i = 1'b0;
    @(posedge clk); #1;
    chk("freeze_release", {ov_d, rslt_d}, 0);

    // reset during MUL iteration 3
    drive(4'd11, 32'd3, 32'd5, 1'b1, 5'd25, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("midrst", {ov_d, busy_d, rslt_d, rq_d, busy_b}, 0);
    outs0 = outs;
    repeat (12) @(posedge clk);
    #1;
    chk("midrst_quiet", outs - outs0, 0);
    push(4'd1, 1'b1, 5'd7, 32'd42, 32'h0);
    drive(4'd1, 32'd40, 32'd2, 1'b1, 5'd7, 32'h0);
    lat(k, st);
    chk("post_rst_add", {k, rslt_d}, {32'd1, 32'd42});
    wait_idle(20);

    // random products against a full-width reference multiply
    for (int i = 0; i < 6; i++) begin
      ra  = $urandom;
      rb  = $urandom;
      rop = (i % 2 == 1) ? 4'd12 : 4'd11;
      p   = {32'h0, ra} * {32'h0, rb};
      push(rop, 1'b1, 5'(i + 1), (rop == 4'd11) ? p[31:0] : p[63:32], 32'h0);
      drive(rop, ra, rb, 1'b1, 5'(i + 1), 32'h0);
      wait_idle(40);
      @(negedge clk);
    end

    repeat (3) @(negedge clk);
    chk("sb_empty", sbq.size(), 0);
    chk("outs_total", outs, pushed);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
